// File: rtl/tt_pkg.sv
// Shared types and sizing for the truth-table capture block.
//   state_t  : run controller states
//   NUM_ROWS : rows in a 4-input truth table
//   ROW_W    : width of the row index
//   CNT_W    : width of the settle counter
`timescale 1ns/1ps
package tt_pkg;
  localparam int unsigned NUM_ROWS = 16;
  localparam int unsigned ROW_W    = 4;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter used to hold each truth-table row for SETTLE cycles.
//   clk, rst_n : clock, async active-low reset
//   load       : reload the counter with SETTLE (wins over en)
//   en         : count down while nonzero
//   zero       : counter is zero (current edge is a sample edge)
`timescale 1ns/1ps
module tt_settle_timer
  import tt_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic zero
);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/truth_table_capture.sv
// Steps x,y,w,z through all 16 rows, samples f_in once per row, builds the
// minterm mask and compares it with a latched golden mask.
//   clk, rst_n      : clock, async active-low reset
//   start, expected : run request (IDLE only) and golden mask, latched on start
//   f_in            : output of the function under test
//   x, y, w, z      : row index bits 3..0
//   busy, done      : run in progress / one-cycle completion pulse
//   minterms        : captured mask, bit i = f_in at row i
//   err_count       : mismatching rows (0..16)
//   first_err(_valid): lowest mismatching row
//   pass            : last completed run had no mismatches
`timescale 1ns/1ps
module truth_table_capture
  import tt_pkg::*;
#(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [NUM_ROWS-1:0] expected,
  input  logic                f_in,
  output logic                x,
  output logic                y,
  output logic                w,
  output logic                z,
  output logic                busy,
  output logic                done,
  output logic [NUM_ROWS-1:0] minterms,
  output logic [4:0]          err_count,
  output logic [ROW_W-1:0]    first_err,
  output logic                first_err_valid,
  output logic                pass
);
  localparam int unsigned        ROWS     = 2 ** N_IN;
  localparam logic [ROW_W-1:0]   LAST_ROW = ROW_W'(ROWS - 1);

  state_t                state, state_n;
  logic [ROW_W-1:0]      idx;
  logic [NUM_ROWS-1:0]   expected_q;
  logic                  tmr_zero;
  logic                  accept;
  logic                  sample;
  logic                  last;
  logic                  mismatch;

  assign accept   = (state == IDLE) && start;
  assign sample   = (state == DRIVE) && tmr_zero;
  assign last     = sample && (idx == LAST_ROW);
  // Case inequality so an X/Z sample counts as a mismatch in simulation.
  assign mismatch = (f_in !== expected_q[idx]);

  tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept || (sample && !last)),
    .en    (state == DRIVE),
    .zero  (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = DRIVE;
      DRIVE:   if (last)  state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx             <= '0;
      expected_q      <= '0;
      busy            <= 1'b0;
      minterms        <= '0;
      err_count       <= '0;
      first_err       <= '0;
      first_err_valid <= 1'b0;
      pass            <= 1'b0;
    end else begin
      if (accept) begin
        expected_q      <= expected;
        minterms        <= '0;
        err_count       <= '0;
        first_err_valid <= 1'b0;
        pass            <= 1'b0;
        idx             <= '0;
        busy            <= 1'b1;
      end
      if (sample) begin
        minterms[idx] <= f_in;
        if (mismatch) begin
          err_count <= err_count + 5'd1;
          if (!first_err_valid) begin
            first_err       <= idx;
            first_err_valid <= 1'b1;
          end
        end
        if (last) begin
          busy <= 1'b0;
        end else begin
          idx <= idx + 1'b1;
        end
      end
      if (state == DONE) begin
        pass <= (err_count == '0);
      end
    end
  end

  // Row lines are forced low outside DRIVE so IDLE/DONE present row 0.
  assign {x, y, w, z} = (state == DRIVE) ? idx : '0;
  assign done         = (state == DONE);
endmodule

// File: tb/tb_truth_table_capture.sv
`timescale 1ns/1ps
module tb_truth_table_capture;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [15:0] exp_a = '0, exp_b = '0;
  int          mode_a = 0, mode_b = 0;
  logic        sel = 1'b0;

  logic        f_a, x_a, y_a, w_a, z_a, busy_a, done_a, fev_a, pass_a;
  logic [15:0] mt_a;
  logic [4:0]  ec_a;
  logic [3:0]  fe_a;
  logic        f_b, x_b, y_b, w_b, z_b, busy_b, done_b, fev_b, pass_b;
  logic [15:0] mt_b;
  logic [4:0]  ec_b;
  logic [3:0]  fe_b;

  int n_cmp = 0;
  int n_bad = 0;

  // Functions under test: 0: f=x, 1: f=z, 2: f=0, 3: f=(x&~y)|(w&z)
  function automatic logic fsel(input int m, input logic [3:0] r);
    case (m)
      0:       return r[3];
      1:       return r[0];
      2:       return 1'b0;
      default: return (r[3] & ~r[2]) | (r[1] & r[0]);
    endcase
  endfunction

  assign f_a = fsel(mode_a, {x_a, y_a, w_a, z_a});
  assign f_b = fsel(mode_b, {x_b, y_b, w_b, z_b});

  logic busy_s, done_s;
  assign busy_s = sel ? busy_b : busy_a;
  assign done_s = sel ? done_b : done_a;

  always #5 clk = ~clk;

  truth_table_capture #(.N_IN(4), .SETTLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .expected(exp_a), .f_in(f_a),
    .x(x_a), .y(y_a), .w(w_a), .z(z_a), .busy(busy_a), .done(done_a),
    .minterms(mt_a), .err_count(ec_a), .first_err(fe_a),
    .first_err_valid(fev_a), .pass(pass_a)
  );

  truth_table_capture #(.N_IN(4), .SETTLE(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .expected(exp_b), .f_in(f_b),
    .x(x_b), .y(y_b), .w(w_b), .z(z_b), .busy(busy_b), .done(done_b),
    .minterms(mt_b), .err_count(ec_b), .first_err(fe_b),
    .first_err_valid(fev_b), .pass(pass_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Called on a negedge. lat = negedges after the start edge until done is seen.
  task automatic run(input logic s, input int m, input logic [15:0] e,
                     output int lat, output int busy_n, output int done_n);
    sel = s;
    if (!s) begin mode_a = m; exp_a = e; start_a = 1'b1; end
    else    begin mode_b = m; exp_b = e; start_b = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    lat = -1; busy_n = 0; done_n = 0;
    for (int k = 0; k < 1000; k++) begin
      if (busy_s) busy_n++;
      if (done_s) begin
        done_n++;
        if (lat < 0) lat = k;
      end
      if (lat >= 0 && k >= lat + 3) break;
      @(negedge clk);
    end
    check("done_seen", 32'(lat >= 0), 32'd1);
  endtask

  task automatic check_a_cleared(input string pfx);
    check({pfx, "_xyzw"}, {x_a, y_a, w_a, z_a}, 4'h0);
    check({pfx, "_busy"}, busy_a, 1'b0);
    check({pfx, "_done"}, done_a, 1'b0);
    check({pfx, "_minterms"}, mt_a, 16'h0000);
    check({pfx, "_err_count"}, ec_a, 5'd0);
    check({pfx, "_first_err"}, fe_a, 4'd0);
    check({pfx, "_fev"}, fev_a, 1'b0);
    check({pfx, "_pass"}, pass_a, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bn, dn;
    bit found, inj7;

    repeat (2) @(negedge clk);
    check_a_cleared("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // f=x, golden FF00
    run(1'b0, 0, 16'hFF00, lat, bn, dn);
    check("t1_latency", lat, 32);
    check("t1_done_width", dn, 1);
    check("t1_busy_cycles", bn, 32);
    check("t1_minterms", mt_a, 16'hFF00);
    check("t1_err_count", ec_a, 5'd0);
    check("t1_fev", fev_a, 1'b0);
    check("t1_pass", pass_a, 1'b1);

    // f=z, golden FF00
    run(1'b0, 1, 16'hFF00, lat, bn, dn);
    check("t2_minterms", mt_a, 16'hAAAA);
    check("t2_err_count", ec_a, 5'd8);
    check("t2_first_err", fe_a, 4'd1);
    check("t2_fev", fev_a, 1'b1);
    check("t2_pass", pass_a, 1'b0);

    // f=0, golden FFFF, SETTLE=3
    run(1'b1, 2, 16'hFFFF, lat, bn, dn);
    check("t3_latency", lat, 64);
    check("t3_busy_cycles", bn, 64);
    check("t3_done_width", dn, 1);
    check("t3_minterms", mt_b, 16'h0000);
    check("t3_err_count", ec_b, 5'd16);
    check("t3_first_err", fe_b, 4'd0);
    check("t3_fev", fev_b, 1'b1);
    check("t3_pass", pass_b, 1'b0);

    // f=(x&~y)|(w&z): rows 3,7,8,9,10,11,15
    run(1'b0, 3, 16'h8F88, lat, bn, dn);
    check("t4a_minterms", mt_a, 16'h8F88);
    check("t4a_err_count", ec_a, 5'd0);
    check("t4a_pass", pass_a, 1'b1);

    // Reset mid-run at row 5
    sel = 1'b0; mode_a = 1; exp_a = 16'hAAAA; start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if ({x_a, y_a, w_a, z_a} == 4'd5) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("t5_reached_row5", found, 1'b1);
    rst_n = 1'b0;
    #1;
    check_a_cleared("t5_midrun");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(1'b0, 1, 16'hAAAA, lat, bn, dn);
    check("t5_latency", lat, 32);
    check("t5_minterms", mt_a, 16'hAAAA);
    check("t5_err_count", ec_a, 5'd0);
    check("t5_pass", pass_a, 1'b1);

    // Golden mask with bit 4 flipped
    run(1'b0, 3, 16'h8F98, lat, bn, dn);
    check("t4b_err_count", ec_a, 5'd1);
    check("t4b_first_err", fe_a, 4'd4);
    check("t4b_pass", pass_a, 1'b0);

    // start pulses at row 7 and during DONE must be ignored
    sel = 1'b0; mode_a = 0; exp_a = 16'hFF00; start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lat = -1; bn = 0; dn = 0; inj7 = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      start_a = 1'b0;
      if (busy_a) bn++;
      if (!inj7 && {x_a, y_a, w_a, z_a} == 4'd7) begin
        start_a = 1'b1;
        inj7 = 1'b1;
      end
      if (done_a) begin
        dn++;
        if (lat < 0) begin
          lat = k;
          start_a = 1'b1;
        end
      end
      if (lat >= 0 && k >= lat + 5) break;
      @(negedge clk);
    end
    start_a = 1'b0;
    check("t6_done_seen", 32'(lat >= 0), 32'd1);
    check("t6_latency", lat, 32);
    check("t6_busy_cycles", bn, 32);
    check("t6_done_width", dn, 1);
    check("t6_busy_after", busy_a, 1'b0);
    check("t6_xyzw_after", {x_a, y_a, w_a, z_a}, 4'h0);
    check("t6_minterms", mt_a, 16'hFF00);
    check("t6_err_count", ec_a, 5'd0);
    check("t6_pass", pass_a, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/truth_table_capture.md
Name: truth_table_capture

Overview:
- Sequential reader for the team's 4-input combinational SoP/PoS blocks.
- Drives x, y, w, z through all 16 rows in order and samples the function output f_in once per row.
- Builds a 16-bit minterm mask from the samples and compares it against an expected mask.
- Reports pass/fail, mismatch count and first failing row, so K-map simplifications are checked in hardware rather than by reading printed tables.

Parameters:
- N_IN, 4: number of function inputs; fixed at 4 in this revision. Row count NUM_ROWS = 2**N_IN = 16.
- SETTLE, 1: cycles each row is held before its sample edge; legal range 1..15.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- start, input, 1: run request; accepted only in IDLE.
- expected, input, 16: golden minterm mask; bit i is the required f_in at row i. Latched on the accepted start.
- f_in, input, 1: output of the function under test.
- x, output, 1: row index bit 3 (MSB).
- y, output, 1: row index bit 2.
- w, output, 1: row index bit 1.
- z, output, 1: row index bit 0 (LSB).
- busy, output, 1: high from the cycle after accepted start until the last sample edge.
- done, output, 1: one-cycle pulse after the last sample.
- minterms, output, 16: captured mask; bit i = f_in sampled at row i.
- err_count, output, 5: number of mismatching rows, 0..16.
- first_err, output, 4: lowest mismatching row index.
- first_err_valid, output, 1: first_err holds a valid row.
- pass, output, 1: last completed run had err_count == 0.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - x, y, w, z, busy, done, pass, first_err_valid = 0.
  - minterms = 16'h0000, err_count = 0, first_err = 0.
  - Applies immediately, including mid-run. No partial results survive.
- Row mapping: row index idx = {x,y,w,z}. Order is 0..15, x slowest and z fastest.
- State machine: IDLE -> DRIVE -> DONE -> IDLE.
- IDLE:
  - Outputs x..z = 0.
  - On start=1 at edge E0:
    - latch expected; clear minterms, err_count, first_err_valid and pass;
    - set idx=0 and settle counter = SETTLE; busy=1; go to DRIVE.
- DRIVE:
  - x..z = idx is held stable for SETTLE+1 cycles.
  - Each edge with counter != 0 decrements the counter.
  - On the edge with counter == 0 (the sample edge):
    - minterms[idx] <= f_in;
    - if f_in != expected_q[idx], then err_count +1, and if first_err_valid == 0, set first_err <= idx and first_err_valid <= 1;
    - if idx == 15, go to DONE and busy <= 0;
    - otherwise idx +1 and counter reloads to SETTLE.
  - Sample edge for row r is E0 + (r+1)*(SETTLE+1). The last sample is at E0 + 16*(SETTLE+1).
- DONE:
  - done = 1 for exactly one cycle; pass <= (err_count == 0), using the final count.
  - Next edge goes to IDLE.
- start behaviour: start in DRIVE or DONE is ignored (not queued). start held high re-launches from IDLE on the next edge after DONE.
- Hold: results (minterms, err_count, first_err*, pass) hold until the next accepted start or reset.
- Counters: the idx counter does not wrap past 15 within a run; err_count saturates naturally at 16 (5 bits).
- f_in is assumed synchronous to clk and settled by the sample edge. An X/Z sample is a mismatch in simulation (compare with !==).

Decomposition:
- Package tt_pkg:
  - state enum {IDLE, DRIVE, DONE};
  - NUM_ROWS = 16;
  - ROW_W = 4;
  - CNT_W = 4 (settle counter width).
- One sub-module is natural: tt_settle_timer. It is a loadable down-counter with a zero flag, taking SETTLE as its parameter.
- Compare/record logic stays in the top.

Test Plan:
- f_in = x, expected = 16'hFF00, SETTLE=1 -> minterms=16'hFF00, err_count=0, first_err_valid=0, pass=1. done pulses exactly 32 cycles after the start edge.
- f_in = z, expected = 16'hFF00 -> minterms=16'hAAAA, err_count=8, first_err=1, first_err_valid=1, pass=0.
- f_in = 0, expected = 16'hFFFF, SETTLE=3 -> minterms=16'h0000, err_count=16, first_err=0. busy is high for 64 cycles; done is one cycle wide.
- f_in driven by a combinational 4-input function, expected = its hand-computed mask -> pass=1. Flip one mask bit k -> err_count=1, first_err=k.
- rst_n pulsed low while idx=5 -> all outputs 0 immediately. A new start then gives a full run from idx=0 with correct results.
- start pulsed again at row 7 and in the DONE cycle -> both ignored; no restart; results unchanged until the next start in IDLE.
